// File: rtl/core_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues halfword requests,
// drops stale responses after redirects and buffers parcels for decode.
//
// state | meaning
// IDLE  | not fetching, nothing in flight
// RUN   | issuing requests while credit allows
// DRAIN | fetch disabled, waiting for in-flight responses to return
module core_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1000_0000),
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [15:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [15:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, resp_pc_q, target_pc;
  logic [CW-1:0]   outstanding_q, outstanding_d, kill_q, fifo_cnt_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [15:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic            flush, credit_ok, issue, push, pop, drop, fifo_nonempty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Masking rather than slicing keeps bit 0 formally consumed.
  assign target_pc     = redirect_pc_i & ~XLEN'(1);
  assign flush         = redirect_i & (state_q != S_IDLE);
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign credit_ok     = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_W;

  assign imem_req_o  = (state_q == S_RUN) & ~redirect_i & credit_ok;
  assign imem_addr_o = fetch_pc_q;
  assign issue       = imem_req_o & imem_gnt_i;

  assign drop = imem_rvalid_i & (kill_q != '0);
  assign push = imem_rvalid_i & (kill_q == '0) & ~flush;

  assign instr_valid_o = fifo_nonempty & ~flush;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = fifo_nonempty ? instr_mem[rd_ptr_q] : '0;
  assign instr_pc_o    = fifo_nonempty ? pc_mem[rd_ptr_q] : '0;
  assign busy_o        = (outstanding_q != '0) | fifo_nonempty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch_en_i) state_d = S_RUN;
      S_RUN:   if (!fetch_en_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (fetch_en_i) state_d = S_RUN;
        else if (outstanding_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !imem_rvalid_i) outstanding_d = outstanding_q + CW'(1);
    else if (!issue && imem_rvalid_i) outstanding_d = outstanding_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (redirect_i) fetch_pc_q <= target_pc;
      else if (issue) fetch_pc_q <= fetch_pc_q + XLEN'(2);
      if (redirect_i) resp_pc_q <= target_pc;
      else if (push) resp_pc_q <= resp_pc_q + XLEN'(2);
      // Everything still in flight after the redirect cycle belongs to the old path.
      if (flush) kill_q <= outstanding_d;
      else if (drop) kill_q <= kill_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_cnt_q == CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Scoreboard bench for core_fetch_ctrl: a queue-based fetch/response model
// predicts requests and delivered parcels; a monitor checks decode output.
module tb_core_fetch_ctrl;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;

  logic        clk_i, rst_i, fetch_en_i, redirect_i;
  logic [31:0] redirect_pc_i, imem_addr_o, instr_pc_o;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [15:0] imem_rdata_i, instr_o;
  logic        instr_valid_o, instr_ready_i, busy_o;

  core_fetch_ctrl #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] addr; logic live; } infl_t;
  typedef struct packed { logic [31:0] pc; logic [15:0] data; } parcel_t;

  infl_t       inflight[$];
  parcel_t     exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_pc;
  logic        en_prev;
  int          n_vec = 0, n_err = 0, n_gnt = 0, n_pop = 0;

  logic        en_k, redir_k;
  logic [31:0] redir_pc_k;
  int          rdy_pct, gnt_pct, rv_pct;

  function automatic logic [15:0] hash(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check at negedge+1, update the model at posedge.
  task automatic step();
    logic  g, rv;
    infl_t e;
    @(negedge clk_i);
    fetch_en_i    = en_k;
    redirect_i    = redir_k;
    redirect_pc_i = redir_pc_k;
    instr_ready_i = ($urandom_range(99, 0) < rdy_pct);
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_pct);
    if (inflight.size() > 0 && $urandom_range(99, 0) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = hash(inflight[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 16'($urandom);
    end
    #1;
    check("req", 32'(imem_req_o),
          32'(en_prev && !redir_k && (inflight.size() + exp_q.size() < DEPTH)));
    check("addr", imem_addr_o, exp_pc);
    check("busy", 32'(busy_o), 32'((inflight.size() + exp_q.size()) != 0));
    g  = imem_req_o & imem_gnt_i;
    rv = imem_rvalid_i;
    @(posedge clk_i);
    if (g) n_gnt++;
    if (rv) begin
      e = inflight.pop_front();
      if (e.live && !redir_k) exp_q.push_back('{pc: e.addr, data: hash(e.addr)});
    end
    if (redir_k) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].live = 1'b0;
      exp_pc = redir_pc_k & ~32'h1;
    end else if (g) begin
      inflight.push_back('{addr: exp_pc, live: 1'b1});
      exp_pc = exp_pc + 32'd2;
    end
    en_prev = en_k;
    redir_k = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    fetch_en_i = 0; redirect_i = 0; redirect_pc_i = '0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = '0; instr_ready_i = 0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_pc", instr_pc_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    inflight.delete();
    exp_q.delete();
    exp_pc  = RESET_PC;
    en_prev = 1'b0;
    en_k    = 1'b0;
    redir_k = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Monitor: every decode handshake pops one expected parcel.
  initial begin : monitor
    parcel_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        check("valid", 32'(instr_valid_o), 32'(exp_q.size() > 0 && !redirect_i));
        if (instr_valid_o && instr_ready_i && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_pop++;
          pop_log.push_back(instr_pc_o);
          check("instr_pc", instr_pc_o, e.pc);
          check("instr", 32'(instr_o), 32'(e.data));
        end
      end
    end
  end

  initial begin : driver
    int g0, p0;
    rst_i = 1'b1;
    fetch_en_i = 0; redirect_i = 0; redirect_pc_i = '0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = '0; instr_ready_i = 0;
    en_k = 0; redir_k = 0; redir_pc_k = '0; en_prev = 0; exp_pc = RESET_PC;
    rdy_pct = 100; gnt_pct = 100; rv_pct = 100;
    do_reset();

    // Streaming at full rate from RESET_PC.
    en_k = 1; repeat (30) step();
    en_k = 0; repeat (12) step();

    // Credit limit with decode stalled, then one pop frees one request.
    rdy_pct = 0; en_k = 1; g0 = n_gnt;
    repeat (20) step();
    check("credit_grants", 32'(n_gnt - g0), 32'(DEPTH));
    rdy_pct = 100; step();
    rdy_pct = 0; g0 = n_gnt;
    repeat (10) step();
    check("regrant", 32'(n_gnt - g0), 32'd1);
    rdy_pct = 100; en_k = 0; repeat (12) step();

    // Disable with three outstanding: no new requests, all delivered, idle.
    en_k = 1; rv_pct = 0; gnt_pct = 100; g0 = n_gnt;
    repeat (4) step();
    check("drain_setup", 32'(n_gnt - g0), 32'd3);
    en_k = 0; gnt_pct = 0; rv_pct = 100; g0 = n_gnt; p0 = n_pop;
    repeat (10) step();
    check("drain_grants", 32'(n_gnt - g0), 32'd0);
    check("drain_parcels", 32'(n_pop - p0), 32'd3);
    #1 check("drain_busy", 32'(busy_o), 32'd0);

    // Redirect while idle only moves the fetch PC.
    redir_k = 1; redir_pc_k = 32'h3000_0000; step();
    en_k = 1; gnt_pct = 100; rv_pct = 100; repeat (10) step();
    en_k = 0; repeat (12) step();

    // Redirect with two outstanding and one buffered.
    en_k = 1; rdy_pct = 0; gnt_pct = 100; rv_pct = 0;
    repeat (4) step();
    gnt_pct = 0; rv_pct = 100; step();
    redir_k = 1; redir_pc_k = 32'h2000_0101; rv_pct = 0; step();
    pop_log.delete();
    rdy_pct = 100; gnt_pct = 100; rv_pct = 100;
    repeat (10) step();
    check("redirect_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h2000_0100);

    // Redirect coincident with a response and no grant.
    rv_pct = 0; repeat (3) step();
    redir_k = 1; redir_pc_k = 32'h0000_4000; gnt_pct = 0; rv_pct = 100; step();
    gnt_pct = 100; repeat (10) step();

    // Address wrap, then reset mid-stream and restart.
    redir_k = 1; redir_pc_k = 32'hFFFF_FFFE; step();
    repeat (6) step();
    do_reset();
    en_k = 1; repeat (10) step();

    // Random traffic.
    rdy_pct = 70; gnt_pct = 70; rv_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) en_k = ($urandom_range(99, 0) < 80);
      if (i == 1500) begin
        do_reset();
        en_k = 1;
      end
      if (en_prev && $urandom_range(99, 0) < 4) begin
        redir_k = 1;
        case ($urandom_range(3, 0))
          0:       redir_pc_k = 32'h2000_0101;
          1:       redir_pc_k = 32'hFFFF_FFFE;
          default: redir_pc_k = $urandom;
        endcase
      end
      step();
    end
    en_k = 0; rdy_pct = 100; rv_pct = 100;
    repeat (20) step();
    #1 check("final_busy", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
